// File: rtl/sprite_row_sequencer_if.sv
// sprite_row_sequencer_if: row handshake between sequencer and sprite frontend.
// start_row/next_vcount/row_visible go to the frontend; fe_done comes back (1 = idle).
interface sprite_row_sequencer_if;
  logic       start_row;
  logic [9:0] next_vcount;
  logic       row_visible;
  logic       fe_done;

  modport master (
    output start_row,
    output next_vcount,
    output row_visible,
    input  fe_done
  );

  modport slave (
    input  start_row,
    input  next_vcount,
    input  row_visible,
    output fe_done
  );
endinterface

// File: rtl/sprite_row_sequencer.sv
// sprite_row_sequencer: launches one sprite row pass per line, ping-pongs line
// buffers, flags overrunning rows and swaps attribute banks at vblank start.
// Ports: clk, reset (sync, high); hcount/vcount VGA counters; fe (row handshake);
// wr_buf/disp_buf line buffer select; commit_req/commit_ack/attr_bank bank swap;
// ovr_clr/overrun/overrun_cnt overrun status.
module sprite_row_sequencer #(
  parameter int unsigned H_TRIG    = 1280,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_TOTAL   = 525,
  parameter int unsigned OVR_W     = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [10:0]          hcount,
  input  logic [9:0]           vcount,
  sprite_row_sequencer_if.master fe,
  output logic                 wr_buf,
  output logic                 disp_buf,
  input  logic                 commit_req,
  output logic                 commit_ack,
  output logic                 attr_bank,
  input  logic                 ovr_clr,
  output logic                 overrun,
  output logic [OVR_W-1:0]     overrun_cnt
);

  localparam logic [10:0] HT   = 11'(H_TRIG);
  localparam logic [9:0]  VVIS = 10'(V_VISIBLE);
  localparam logic [9:0]  VLST = 10'(V_TOTAL - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_BUSY
  } state_t;

  state_t     state_q;
  state_t     state_d;
  logic [10:0] hcount_q;
  logic       commit_req_q;
  logic       commit_pending;
  logic       trig;
  logic       ovr_evt;
  logic       do_commit;
  logic [9:0] nv;

  // hcount may dwell on H_TRIG; fire only on the cycle it arrives.
  assign trig = (hcount == HT) && (hcount_q != HT);
  assign nv   = (vcount == VLST) ? 10'd0 : vcount + 10'd1;

  // First trigger of vblank is the only point where a bank swap is safe.
  assign do_commit = trig && (nv == VVIS) && commit_pending;

  assign disp_buf = ~wr_buf;

  always_comb begin
    state_d = state_q;
    ovr_evt = 1'b0;
    if (trig) begin
      state_d = S_ARM;
      ovr_evt = (state_q == S_ARM) ||
                ((state_q == S_BUSY) && !fe.fe_done);
    end else begin
      unique case (1'b1)
        // fe_done still reads idle here: frontend drops it a cycle late.
        (state_q == S_ARM):  state_d = S_BUSY;
        (state_q == S_BUSY): if (fe.fe_done) state_d = S_IDLE;
        default:             state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      hcount_q       <= '0;
      fe.start_row   <= 1'b0;
      fe.next_vcount <= '0;
      fe.row_visible <= 1'b0;
      wr_buf         <= 1'b0;
      commit_req_q   <= 1'b0;
      commit_pending <= 1'b0;
      commit_ack     <= 1'b0;
      attr_bank      <= 1'b0;
      overrun        <= 1'b0;
      overrun_cnt    <= '0;
    end else begin
      state_q      <= state_d;
      hcount_q     <= hcount;
      commit_req_q <= commit_req;
      fe.start_row <= trig;
      commit_ack   <= do_commit;

      if (trig) begin
        fe.next_vcount <= nv;
        fe.row_visible <= (nv < VVIS);
        if (vcount < VVIS) wr_buf <= ~wr_buf;
      end

      // Rising-edge capture so a held request commits only once.
      if (commit_req && !commit_req_q) commit_pending <= 1'b1;
      else if (do_commit)              commit_pending <= 1'b0;

      if (do_commit) attr_bank <= ~attr_bank;

      if (ovr_clr) begin
        overrun     <= 1'b0;
        overrun_cnt <= '0;
      end else if (ovr_evt) begin
        overrun <= 1'b1;
        if (overrun_cnt != '1)
          overrun_cnt <= overrun_cnt + OVR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_sprite_row_sequencer.sv
// tb_sprite_row_sequencer: directed bench for sprite_row_sequencer.
// Each task drives one scenario and checks hand-computed expectations.
module tb_sprite_row_sequencer;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [10:0] hcount = '0;
  logic [9:0]  vcount = '0;
  logic        commit_req = 1'b0;
  logic        ovr_clr = 1'b0;
  logic        wr_buf, disp_buf, commit_ack, attr_bank, overrun;
  logic [7:0]  overrun_cnt;
  int          tests_run = 0;
  int          failed = 0;

  sprite_row_sequencer_if fe_if ();

  always #5 clk = ~clk;

  sprite_row_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .hcount      (hcount),
    .vcount      (vcount),
    .fe          (fe_if),
    .wr_buf      (wr_buf),
    .disp_buf    (disp_buf),
    .commit_req  (commit_req),
    .commit_ack  (commit_ack),
    .attr_bank   (attr_bank),
    .ovr_clr     (ovr_clr),
    .overrun     (overrun),
    .overrun_cnt (overrun_cnt)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Idle cycle off H_TRIG, then the trigger cycle; returns in the start_row cycle.
  task automatic trigger(input logic [9:0] vc);
    hcount = 11'd0;
    tick;
    vcount = vc;
    hcount = 11'd1280;
    tick;
  endtask

  task automatic do_reset;
    hcount = 11'd0;
    reset = 1'b1;
    tick;
    tick;
    reset = 1'b0;
  endtask

  task automatic test_reset;
    do_reset;
    tests_run++;
    if ({fe_if.start_row, fe_if.row_visible, wr_buf, disp_buf, attr_bank,
         commit_ack, overrun} !== 7'b0001000) begin
      failed++;
      $display("FAIL reset_flags: got %b want 0001000", {fe_if.start_row,
        fe_if.row_visible, wr_buf, disp_buf, attr_bank, commit_ack, overrun});
    end
    tests_run++;
    if (fe_if.next_vcount !== 10'd0) begin
      failed++;
      $display("FAIL reset_nv: got %0d want 0", fe_if.next_vcount);
    end
    tests_run++;
    if (overrun_cnt !== 8'd0) begin
      failed++;
      $display("FAIL reset_cnt: got %0d want 0", overrun_cnt);
    end
  endtask

  task automatic test_trigger_hold;
    fe_if.fe_done = 1'b1;
    trigger(10'd10);
    tests_run++;
    if ({fe_if.start_row, fe_if.next_vcount, fe_if.row_visible, wr_buf,
         disp_buf} !== {1'b1, 10'd11, 1'b1, 1'b1, 1'b0}) begin
      failed++;
      $display("FAIL hold_first: got sr=%b nv=%0d rv=%b wr=%b dp=%b want 1 11 1 1 0",
        fe_if.start_row, fe_if.next_vcount, fe_if.row_visible, wr_buf, disp_buf);
    end
    tick;
    tests_run++;
    if (fe_if.start_row !== 1'b0) begin
      failed++;
      $display("FAIL hold_second: got sr=%b want 0", fe_if.start_row);
    end
    tests_run++;
    if (fe_if.next_vcount !== 10'd11) begin
      failed++;
      $display("FAIL hold_nv: got %0d want 11", fe_if.next_vcount);
    end
  endtask

  task automatic test_wrap;
    trigger(10'd524);
    tests_run++;
    if ({fe_if.start_row, fe_if.next_vcount, fe_if.row_visible, wr_buf}
        !== {1'b1, 10'd0, 1'b1, 1'b1}) begin
      failed++;
      $display("FAIL wrap_524: got sr=%b nv=%0d rv=%b wr=%b want 1 0 1 1",
        fe_if.start_row, fe_if.next_vcount, fe_if.row_visible, wr_buf);
    end
    trigger(10'd479);
    tests_run++;
    if ({fe_if.next_vcount, fe_if.row_visible, wr_buf, disp_buf}
        !== {10'd480, 1'b0, 1'b0, 1'b1}) begin
      failed++;
      $display("FAIL last_vis_479: got nv=%0d rv=%b wr=%b dp=%b want 480 0 0 1",
        fe_if.next_vcount, fe_if.row_visible, wr_buf, disp_buf);
    end
    trigger(10'd480);
    tests_run++;
    if ({fe_if.next_vcount, fe_if.row_visible, wr_buf}
        !== {10'd481, 1'b0, 1'b0}) begin
      failed++;
      $display("FAIL blank_480: got nv=%0d rv=%b wr=%b want 481 0 0",
        fe_if.next_vcount, fe_if.row_visible, wr_buf);
    end
    tests_run++;
    if (overrun !== 1'b0) begin
      failed++;
      $display("FAIL wrap_no_ovr: got %b want 0", overrun);
    end
  endtask

  task automatic test_fsm;
    do_reset;
    fe_if.fe_done = 1'b1;
    trigger(10'd20);
    tick;
    fe_if.fe_done = 1'b0;
    tick;
    tick;
    tick;
    fe_if.fe_done = 1'b1;
    tick;
    fe_if.fe_done = 1'b0;
    trigger(10'd21);
    tests_run++;
    if ({overrun, overrun_cnt} !== {1'b0, 8'd0}) begin
      failed++;
      $display("FAIL fsm_idle_trig: got ovr=%b cnt=%0d want 0 0",
        overrun, overrun_cnt);
    end
    // fe_done high only in the arm cycle must be ignored.
    fe_if.fe_done = 1'b1;
    hcount = 11'd0;
    tick;
    fe_if.fe_done = 1'b0;
    vcount = 10'd22;
    hcount = 11'd1280;
    tick;
    tests_run++;
    if ({fe_if.start_row, overrun, overrun_cnt} !== {1'b1, 1'b1, 8'd1}) begin
      failed++;
      $display("FAIL fsm_arm_ignore: got sr=%b ovr=%b cnt=%0d want 1 1 1",
        fe_if.start_row, overrun, overrun_cnt);
    end
  endtask

  task automatic test_saturation;
    fe_if.fe_done = 1'b0;
    for (int i = 0; i < 3; i++) trigger(10'd500);
    tests_run++;
    if (overrun_cnt !== 8'd4) begin
      failed++;
      $display("FAIL ovr_count4: got %0d want 4", overrun_cnt);
    end
    for (int i = 0; i < 300; i++) trigger(10'd500);
    tests_run++;
    if ({overrun, overrun_cnt} !== {1'b1, 8'd255}) begin
      failed++;
      $display("FAIL ovr_saturate: got ovr=%b cnt=%0d want 1 255",
        overrun, overrun_cnt);
    end
    hcount = 11'd0;
    tick;
    hcount = 11'd1280;
    ovr_clr = 1'b1;
    tick;
    ovr_clr = 1'b0;
    tests_run++;
    if ({fe_if.start_row, overrun, overrun_cnt} !== {1'b1, 1'b0, 8'd0}) begin
      failed++;
      $display("FAIL clr_wins: got sr=%b ovr=%b cnt=%0d want 1 0 0",
        fe_if.start_row, overrun, overrun_cnt);
    end
    trigger(10'd500);
    tests_run++;
    if ({overrun, overrun_cnt} !== {1'b1, 8'd1}) begin
      failed++;
      $display("FAIL after_clr: got ovr=%b cnt=%0d want 1 1", overrun, overrun_cnt);
    end
  endtask

  task automatic test_commit;
    do_reset;
    fe_if.fe_done = 1'b1;
    vcount = 10'd100;
    commit_req = 1'b1;
    tick;
    commit_req = 1'b0;
    tick;
    trigger(10'd200);
    tests_run++;
    if ({commit_ack, attr_bank} !== 2'b00) begin
      failed++;
      $display("FAIL commit_early: got ack=%b bank=%b want 0 0", commit_ack, attr_bank);
    end
    trigger(10'd479);
    tests_run++;
    if ({commit_ack, attr_bank} !== 2'b11) begin
      failed++;
      $display("FAIL commit_vblank: got ack=%b bank=%b want 1 1", commit_ack, attr_bank);
    end
    tick;
    tests_run++;
    if ({commit_ack, attr_bank} !== 2'b01) begin
      failed++;
      $display("FAIL commit_pulse: got ack=%b bank=%b want 0 1", commit_ack, attr_bank);
    end
    trigger(10'd479);
    tests_run++;
    if ({commit_ack, attr_bank} !== 2'b01) begin
      failed++;
      $display("FAIL commit_none: got ack=%b bank=%b want 0 1", commit_ack, attr_bank);
    end
    commit_req = 1'b1;
    tick;
    trigger(10'd479);
    tests_run++;
    if ({commit_ack, attr_bank} !== 2'b10) begin
      failed++;
      $display("FAIL held_first: got ack=%b bank=%b want 1 0", commit_ack, attr_bank);
    end
    trigger(10'd100);
    trigger(10'd479);
    tests_run++;
    if ({commit_ack, attr_bank} !== 2'b00) begin
      failed++;
      $display("FAIL held_second: got ack=%b bank=%b want 0 0", commit_ack, attr_bank);
    end
    commit_req = 1'b0;
    tick;
    commit_req = 1'b1;
    tick;
    commit_req = 1'b0;
    trigger(10'd490);
    tests_run++;
    if (commit_ack !== 1'b0) begin
      failed++;
      $display("FAIL blank_req_wait: got ack=%b want 0", commit_ack);
    end
    trigger(10'd479);
    tests_run++;
    if ({commit_ack, attr_bank} !== 2'b11) begin
      failed++;
      $display("FAIL rearm: got ack=%b bank=%b want 1 1", commit_ack, attr_bank);
    end
  endtask

  task automatic test_reset_mid_row;
    fe_if.fe_done = 1'b1;
    hcount = 11'd0;
    tick;
    tick;
    fe_if.fe_done = 1'b0;
    for (int i = 0; i < 6; i++) trigger(10'(30 + i));
    tick;
    tests_run++;
    if (overrun_cnt !== 8'd5) begin
      failed++;
      $display("FAIL pre_reset_cnt: got %0d want 5", overrun_cnt);
    end
    hcount = 11'd0;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    tests_run++;
    if ({fe_if.start_row, fe_if.row_visible, wr_buf, disp_buf, attr_bank,
         commit_ack, overrun, overrun_cnt, fe_if.next_vcount}
        !== {7'b0001000, 8'd0, 10'd0}) begin
      failed++;
      $display("FAIL mid_reset: got sr=%b rv=%b wr=%b dp=%b bk=%b ack=%b ovr=%b cnt=%0d nv=%0d",
        fe_if.start_row, fe_if.row_visible, wr_buf, disp_buf, attr_bank,
        commit_ack, overrun, overrun_cnt, fe_if.next_vcount);
    end
    trigger(10'd40);
    tests_run++;
    if ({fe_if.start_row, fe_if.next_vcount, overrun, overrun_cnt, wr_buf}
        !== {1'b1, 10'd41, 1'b0, 8'd0, 1'b1}) begin
      failed++;
      $display("FAIL post_reset_trig: got sr=%b nv=%0d ovr=%b cnt=%0d wr=%b want 1 41 0 0 1",
        fe_if.start_row, fe_if.next_vcount, overrun, overrun_cnt, wr_buf);
    end
  endtask

  initial begin
    fe_if.fe_done = 1'b1;
    test_reset;
    test_trigger_hold;
    test_wrap;
    test_fsm;
    test_saturation;
    test_commit;
    test_reset_mid_row;
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
